// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and clear-vector helper for the
// registered 8:3 priority encoder.
package enc_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // One-hot vector with only bit `idx` set; used to retire an accepted event.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pri_enc83.sv
// Combinational 8:3 priority encoder: bit 7 has the highest priority.
module pri_enc83
    import enc_pkg::*;
(
    input  logic [N-1:0]  data_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan upward so the highest set bit is the last assignment to win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (data_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/enc83_irq.sv
// Registered 8:3 priority encoder with sticky request capture and a
// valid/ready offer handshake. Pending bits are retired on acceptance;
// a simultaneous new request on the same bit keeps it pending.
module enc83_irq
    import enc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic          valid,
    output logic [IW-1:0] idx,
    input  logic          ready,
    output logic [N-1:0]  pend
);

    state_e        state_q, state_d;
    logic [N-1:0]  pend_q,  pend_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [N-1:0]  clr;
    logic [N-1:0]  cand;
    logic          found;
    logic [IW-1:0] sel_idx;

    assign cand = pend_q & ~mask;

    pri_enc83 u_pri (
        .data_i  (cand),
        .found_o (found),
        .idx_o   (sel_idx)
    );

    // Next-state, offer registers and pending update.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else begin
                    valid_d = 1'b0;
                end
            end
            OFFER: begin
                // Offer is frozen until accepted; new arrivals and mask changes are ignored here.
                if (ready) begin
                    clr     = onehot(idx_q);
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        // Set term is OR'd last so a same-cycle request wins over the clear.
        pend_d = (pend_q & ~clr) | (req & {N{en}});
    end

    // State, pending and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign valid = valid_q;
    assign idx   = idx_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_enc83_irq.sv
// Self-checking bench for enc83_irq: per-feature tasks with inline checks,
// plus a scoreboard of expected accepted indices popped at each handshake.
module tb_enc83_irq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       valid;
    logic [2:0] idx;
    logic       ready;
    logic [7:0] pend;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    enc83_irq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .mask  (mask),
        .valid (valid),
        .idx   (idx),
        .ready (ready),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: an accept happens at the next rising edge when valid&ready.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_accept: idx=%0d accepted, no accept expected", idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(idx) != e) begin
                    errors++;
                    $display("FAIL sb_accept_idx: got %0d expected %0d", idx, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = '0; mask = '0; ready = 1'b0;
        #2;
        checks++;
        if (valid !== 1'b0 || idx !== 3'd0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: valid=%b idx=%0d pend=%h expected 0 0 00", valid, idx, pend);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: valid=%b pend=%h expected 0 00", valid, pend);
        end
    endtask

    task automatic test_single();
        en = 1'b1; ready = 1'b1; mask = '0;
        req = 8'h08;
        exp_q.push_back(3);
        tick();
        req = '0;
        checks++;
        if (valid !== 1'b0 || pend !== 8'h08) begin
            errors++;
            $display("FAIL single_capture: valid=%b pend=%h expected 0 08", valid, pend);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd3) begin
            errors++;
            $display("FAIL single_offer: valid=%b idx=%0d expected 1 3", valid, idx);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL single_retire: valid=%b pend=%h expected 0 00", valid, pend);
        end
    endtask

    task automatic test_priority_hold();
        ready = 1'b0;
        req = 8'h05;
        tick();
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd2) begin
            errors++;
            $display("FAIL prio_first: valid=%b idx=%0d expected 1 2", valid, idx);
        end
        req = 8'h80;
        tick();
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd2 || pend !== 8'h85) begin
            errors++;
            $display("FAIL prio_hold: valid=%b idx=%0d pend=%h expected 1 2 85", valid, idx, pend);
        end
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(0);
        ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || valid); c++) tick();
        checks++;
        if (exp_q.size() != 0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL prio_drain: left=%0d pend=%h expected 0 00", exp_q.size(), pend);
        end
    endtask

    task automatic test_mask();
        ready = 1'b0; mask = 8'h80;
        req = 8'hC0;
        tick();
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd6) begin
            errors++;
            $display("FAIL mask_offer: valid=%b idx=%0d expected 1 6", valid, idx);
        end
        exp_q.push_back(6);
        ready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (valid !== 1'b0 || pend !== 8'h80) begin
                errors++;
                $display("FAIL mask_block: valid=%b pend=%h expected 0 80", valid, pend);
            end
            tick();
        end
        exp_q.push_back(7);
        mask = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd7) begin
            errors++;
            $display("FAIL mask_release: valid=%b idx=%0d expected 1 7", valid, idx);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mask_done: valid=%b pend=%h left=%0d expected 0 00 0", valid, pend, exp_q.size());
        end
    endtask

    task automatic test_set_wins();
        ready = 1'b1; mask = '0;
        for (int k = 0; k < 5; k++) exp_q.push_back(4);
        req = 8'h10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (pend[4] !== 1'b1 || valid !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL setwins_cycle%0d: pend=%h valid=%b expected pend[4]=1 valid=%0d",
                         k, pend, valid, (k % 2) == 0);
            end
        end
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL setwins_done: valid=%b pend=%h left=%0d expected 0 00 0", valid, pend, exp_q.size());
        end
    endtask

    task automatic test_enable();
        en = 1'b0; ready = 1'b1; req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || pend !== 8'h00) begin
                errors++;
                $display("FAIL en_gate: valid=%b pend=%h expected 0 00", valid, pend);
            end
        end
        for (int b = 7; b >= 0; b--) exp_q.push_back(b);
        en = 1'b1;
        tick();
        en = 1'b0; req = '0;
        checks++;
        if (pend !== 8'hFF) begin
            errors++;
            $display("FAIL en_capture: pend=%h expected ff", pend);
        end
        for (int c = 0; c < 40 && (exp_q.size() != 0 || valid); c++) tick();
        checks++;
        if (exp_q.size() != 0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL en_drain: left=%0d pend=%h expected 0 00", exp_q.size(), pend);
        end
    endtask

    task automatic test_reset_mid_offer();
        en = 1'b1; ready = 1'b0; mask = '0;
        req = 8'h20;
        tick();
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_offer: valid=%b idx=%0d expected 1 5", valid, idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || idx !== 3'd0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b idx=%0d pend=%h expected 0 0 00", valid, idx, pend);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_after: valid=%b pend=%h expected 0 00", valid, pend);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_hold();
        test_mask();
        test_set_wins();
        test_enable();
        test_reset_mid_offer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
